// File: rtl/seq_det_pkg.sv
// Shared constants, configuration record and length clamp for the serial sequence detector.
package seq_det_pkg;

  localparam int DEF_PAT_W = 8;
  localparam int DEF_CNT_W = 8;

  // Widest pattern the config record can carry; instances use the low PAT_W bits.
  localparam int PAT_MAX   = 64;
  localparam int LEN_MAX_W = 7;

  typedef struct packed {
    logic [PAT_MAX-1:0]   pattern;
    logic [PAT_MAX-1:0]   mask;
    logic [LEN_MAX_W-1:0] len;
    logic                 overlap;
  } cfg_t;

  function automatic logic [LEN_MAX_W-1:0] clamp_len(input logic [LEN_MAX_W-1:0] len,
                                                     input int unsigned           pat_w);
    if (32'(len) > pat_w) return LEN_MAX_W'(pat_w);
    return len;
  endfunction

endpackage

// File: rtl/seq_det_if.sv
// Config, serial data and status bundle between the detector and its host logic.
interface seq_det_if #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8
);
  localparam int LEN_W = $clog2(PAT_W + 1);

  logic             cfg_load;
  logic [PAT_W-1:0] cfg_pattern;
  logic [PAT_W-1:0] cfg_mask;
  logic [LEN_W-1:0] cfg_len;
  logic             cfg_overlap;
  logic             data_valid;
  logic             data;
  logic             cnt_clr;
  logic             flag;
  logic [CNT_W-1:0] match_cnt;

  modport master (
    output cfg_load, cfg_pattern, cfg_mask, cfg_len, cfg_overlap,
    output data_valid, data, cnt_clr,
    input  flag, match_cnt
  );

  modport slave (
    input  cfg_load, cfg_pattern, cfg_mask, cfg_len, cfg_overlap,
    input  data_valid, data, cnt_clr,
    output flag, match_cnt
  );
endinterface

// File: rtl/seq_det_cmp.sv
// Masked compare of the candidate window against the pattern over the low len bits.
// Purely combinational; no backpressure.
module seq_det_cmp #(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4
) (
  input  logic [PAT_W-1:0] nxt_i,
  input  logic [PAT_W-1:0] pattern_i,
  input  logic [PAT_W-1:0] mask_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             eq_o
);
  logic [PAT_W-1:0] len_en;

  always_comb begin
    len_en = '0;
    for (int i = 0; i < PAT_W; i++) begin
      len_en[i] = (32'(len_i) > 32'(i));
    end
  end

  assign eq_o = ~|((nxt_i ^ pattern_i) & mask_i & len_en);
endmodule

// File: rtl/seq_detect_param.sv
// Programmable serial sequence detector: registered one-cycle match flag, saturating match counter.
// Flag one cycle after the final pattern bit; data qualified by data_valid, never stalls.
module seq_detect_param
  import seq_det_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic      clk,
  input  logic      rst,
  seq_det_if.slave  bus
);
  localparam int LEN_W = $clog2(PAT_W + 1);

  cfg_t             cfg_q, cfg_d;
  logic [PAT_W-1:0] hist_q, hist_d;
  logic [LEN_W-1:0] fill_q, fill_d;
  logic             flag_q, flag_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [PAT_W-1:0] nxt;
  logic [LEN_W-1:0] len_eff;
  logic             fill_ok;
  logic             eq;
  logic             match;
  logic             unused_cfg;

  assign nxt     = {hist_q[PAT_W-2:0], bus.data};
  assign len_eff = LEN_W'(clamp_len(cfg_q.len, PAT_W));
  // fill counts bits already held, so the incoming bit completes the window at fill+1
  assign fill_ok = (({1'b0, fill_q} + (LEN_W+1)'(1)) >= {1'b0, len_eff});

  seq_det_cmp #(
    .PAT_W (PAT_W),
    .LEN_W (LEN_W)
  ) u_cmp (
    .nxt_i     (nxt),
    .pattern_i (cfg_q.pattern[PAT_W-1:0]),
    .mask_i    (cfg_q.mask[PAT_W-1:0]),
    .len_i     (len_eff),
    .eq_o      (eq)
  );

  assign match = !bus.cfg_load && bus.data_valid && (len_eff != '0) && fill_ok && eq;

  assign unused_cfg = ^{cfg_q.pattern >> PAT_W, cfg_q.mask >> PAT_W};

  always_comb begin
    cfg_d  = cfg_q;
    hist_d = hist_q;
    fill_d = fill_q;
    flag_d = match;
    cnt_d  = cnt_q;

    if (bus.cfg_load) begin
      cfg_d.pattern = PAT_MAX'(bus.cfg_pattern);
      cfg_d.mask    = PAT_MAX'(bus.cfg_mask);
      cfg_d.len     = LEN_MAX_W'(bus.cfg_len);
      cfg_d.overlap = bus.cfg_overlap;
      hist_d        = '0;
      fill_d        = '0;
    end else if (bus.data_valid) begin
      hist_d = nxt;
      if (match && !cfg_q.overlap) begin
        fill_d = '0;
      end else if (fill_q < LEN_W'(PAT_W)) begin
        fill_d = fill_q + LEN_W'(1);
      end
    end

    if (bus.cnt_clr) begin
      cnt_d = '0;
    end else if (match && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cfg_q.pattern <= '0;
      cfg_q.mask    <= '0;
      cfg_q.len     <= '0;
      cfg_q.overlap <= 1'b1;
      hist_q        <= '0;
      fill_q        <= '0;
      flag_q        <= 1'b0;
      cnt_q         <= '0;
    end else begin
      cfg_q  <= cfg_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      flag_q <= flag_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.flag      = flag_q;
  assign bus.match_cnt = cnt_q;
endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param with PAT_W=8, CNT_W=4.
module tb_seq_detect_param;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  seq_det_if #(.PAT_W(8), .CNT_W(4)) bus ();

  seq_detect_param #(.PAT_W(8), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic step(input logic v, input logic d, input logic clr);
    bus.data_valid = v;
    bus.data       = d;
    bus.cnt_clr    = clr;
    @(posedge clk);
    #1;
    bus.data_valid = 1'b0;
    bus.cnt_clr    = 1'b0;
  endtask

  task automatic load(input logic [7:0] pat, input logic [7:0] msk, input logic [3:0] len,
                      input logic ovl);
    bus.cfg_pattern = pat;
    bus.cfg_mask    = msk;
    bus.cfg_len     = len;
    bus.cfg_overlap = ovl;
    bus.cfg_load    = 1'b1;
    @(posedge clk);
    #1;
    bus.cfg_load    = 1'b0;
  endtask

  task automatic test_reset();
    bus.cfg_load = 0; bus.cfg_pattern = 0; bus.cfg_mask = 0; bus.cfg_len = 0;
    bus.cfg_overlap = 0; bus.data_valid = 0; bus.data = 0; bus.cnt_clr = 0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (bus.flag !== 1'b0 || bus.match_cnt !== 4'd0) begin
      fails++;
      $display("FAIL reset_state: flag=%b cnt=%0d, want flag=0 cnt=0", bus.flag, bus.match_cnt);
    end
    rst = 1'b1;
    // Reset config has len 0: an all-ones stream must not flag before any load.
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b1, 1'b0);
      tests++;
      if (bus.flag !== 1'b0) begin
        fails++;
        $display("FAIL reset_disabled bit%0d: flag=%b want 0", i, bus.flag);
      end
    end
  endtask

  task automatic test_overlap();
    logic [6:0] bits = 7'b1011011;
    logic [6:0] exp  = 7'b0001001;
    load(8'h0B, 8'h0F, 4'd4, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) begin
      step(1'b1, bits[6-i], 1'b0);
      tests++;
      if (bus.flag !== exp[6-i]) begin
        fails++;
        $display("FAIL overlap_flag bit%0d: flag=%b want %b", i + 1, bus.flag, exp[6-i]);
      end
    end
    tests++;
    if (bus.match_cnt !== 4'd2) begin
      fails++;
      $display("FAIL overlap_cnt: got %0d want 2", bus.match_cnt);
    end
  endtask

  task automatic test_nonoverlap();
    logic [10:0] bits = 11'b1011011_1011;
    logic [10:0] exp  = 11'b0001000_0001;
    load(8'h0B, 8'h0F, 4'd4, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 11; i++) begin
      step(1'b1, bits[10-i], 1'b0);
      tests++;
      if (bus.flag !== exp[10-i]) begin
        fails++;
        $display("FAIL nonoverlap_flag bit%0d: flag=%b want %b", i + 1, bus.flag, exp[10-i]);
      end
      if (i == 6) begin
        tests++;
        if (bus.match_cnt !== 4'd1) begin
          fails++;
          $display("FAIL nonoverlap_cnt1: got %0d want 1", bus.match_cnt);
        end
      end
    end
    tests++;
    if (bus.match_cnt !== 4'd2) begin
      fails++;
      $display("FAIL nonoverlap_cnt2: got %0d want 2", bus.match_cnt);
    end
  endtask

  task automatic test_valid_gaps();
    logic [6:0] bits = 7'b1011011;
    logic [6:0] exp  = 7'b0001001;
    int         gaps[7] = '{2, 1, 3, 2, 1, 3, 1};
    load(8'h0B, 8'h0F, 4'd4, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) begin
      step(1'b1, bits[6-i], 1'b0);
      tests++;
      if (bus.flag !== exp[6-i]) begin
        fails++;
        $display("FAIL gaps_flag bit%0d: flag=%b want %b", i + 1, bus.flag, exp[6-i]);
      end
      for (int g = 0; g < gaps[i]; g++) begin
        step(1'b0, 1'($urandom_range(1)), 1'b0);
        tests++;
        if (bus.flag !== 1'b0) begin
          fails++;
          $display("FAIL gaps_invalid bit%0d gap%0d: flag=%b want 0", i + 1, g, bus.flag);
        end
      end
    end
    tests++;
    if (bus.match_cnt !== 4'd2) begin
      fails++;
      $display("FAIL gaps_cnt: got %0d want 2", bus.match_cnt);
    end
  endtask

  task automatic test_mask_len();
    logic [3:0] streams[3] = '{4'b1001, 4'b1101, 4'b1000};
    logic       want[3]    = '{1'b1, 1'b1, 1'b0};
    logic [7:0] pat9       = 8'hA5;
    logic [3:0] exp2       = 4'b0111;
    for (int s = 0; s < 3; s++) begin
      load(8'b0000_1001, 8'b0000_1011, 4'd4, 1'b1);
      for (int i = 0; i < 4; i++) begin
        step(1'b1, streams[s][3-i], 1'b0);
        tests++;
        if (bus.flag !== ((i == 3) ? want[s] : 1'b0)) begin
          fails++;
          $display("FAIL mask_stream%0d bit%0d: flag=%b want %b", s, i + 1, bus.flag,
                   (i == 3) ? want[s] : 1'b0);
        end
      end
    end
    // len 9 clamps to 8: the match lands on the 8th bit, not the 9th.
    load(8'hA5, 8'hFF, 4'd9, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, pat9[7-i], 1'b0);
      tests++;
      if (bus.flag !== (i == 7)) begin
        fails++;
        $display("FAIL len9_clamp bit%0d: flag=%b want %b", i + 1, bus.flag, (i == 7));
      end
    end
    load(8'h00, 8'h00, 4'd0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'(i), 1'b0);
      tests++;
      if (bus.flag !== 1'b0) begin
        fails++;
        $display("FAIL len0 bit%0d: flag=%b want 0", i + 1, bus.flag);
      end
    end
    load(8'h00, 8'h00, 4'd2, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'(i), 1'b0);
      tests++;
      if (bus.flag !== exp2[3-i]) begin
        fails++;
        $display("FAIL zero_mask bit%0d: flag=%b want %b", i + 1, bus.flag, exp2[3-i]);
      end
    end
  endtask

  task automatic test_counter();
    load(8'h00, 8'h00, 4'd1, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b1, 1'(i), 1'b0);
    tests++;
    if (bus.match_cnt !== 4'd15) begin
      fails++;
      $display("FAIL cnt_saturate: got %0d want 15", bus.match_cnt);
    end
    step(1'b1, 1'b1, 1'b1);
    tests++;
    if (bus.match_cnt !== 4'd0 || bus.flag !== 1'b1) begin
      fails++;
      $display("FAIL cnt_clr_on_match: cnt=%0d flag=%b want cnt=0 flag=1", bus.match_cnt, bus.flag);
    end
    step(1'b1, 1'b0, 1'b0);
    tests++;
    if (bus.match_cnt !== 4'd1) begin
      fails++;
      $display("FAIL cnt_after_clr: got %0d want 1", bus.match_cnt);
    end
  endtask

  task automatic test_midstream();
    load(8'h0B, 8'h0F, 4'd4, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    #2 rst = 1'b0;
    #2;
    tests++;
    if (bus.match_cnt !== 4'd0 || bus.flag !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: cnt=%0d flag=%b want 0/0", bus.match_cnt, bus.flag);
    end
    rst = 1'b1;
    step(1'b1, 1'b1, 1'b0);
    tests++;
    if (bus.flag !== 1'b0 || bus.match_cnt !== 4'd0) begin
      fails++;
      $display("FAIL reset_span: flag=%b cnt=%0d want 0/0", bus.flag, bus.match_cnt);
    end
    load(8'h0B, 8'h0F, 4'd4, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    tests++;
    if (bus.flag !== 1'b1 || bus.match_cnt !== 4'd1) begin
      fails++;
      $display("FAIL reload_match: flag=%b cnt=%0d want 1/1", bus.flag, bus.match_cnt);
    end
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    load(8'h0B, 8'h0F, 4'd4, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    tests++;
    if (bus.flag !== 1'b0 || bus.match_cnt !== 4'd1) begin
      fails++;
      $display("FAIL cfg_load_span: flag=%b cnt=%0d want 0/1", bus.flag, bus.match_cnt);
    end
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    tests++;
    if (bus.flag !== 1'b1 || bus.match_cnt !== 4'd2) begin
      fails++;
      $display("FAIL after_cfg_load: flag=%b cnt=%0d want 1/2", bus.flag, bus.match_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_overlap();
    test_nonoverlap();
    test_valid_gaps();
    test_mask_len();
    test_counter();
    test_midstream();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/seq_detect_param.md
Name: seq_detect_param

Overview:
- Parametrised serial bit-sequence detector, successor to the fixed 4-bit "1011" detector.
- Runtime-programmable pattern, length and per-bit don't-care mask; input valid qualifier; overlap or non-overlap mode; saturating match counter.
- Sits on a single-bit serial data path; the flag feeds downstream framing/sync logic, and the counter feeds status registers.

Parameters:
- PAT_W, 8, maximum pattern length in bits (>=2).
- CNT_W, 8, width of the match counter.
- LEN_W, $clog2(PAT_W+1), width of the pat_len port (derived, not overridden).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- cfg_load  in  1  pulse; latch the configuration and clear detection history.
- cfg_pattern  in  PAT_W  expected bits; bit [len-1] is the first received, bit [0] the last.
- cfg_mask  in  PAT_W  1 = compare this bit, 0 = don't-care.
- cfg_len  in  LEN_W  active pattern length.
- cfg_overlap  in  1  1 = overlapping matches allowed.
- data_valid  in  1  data is sampled only when high.
- data  in  1  serial input bit.
- cnt_clr  in  1  synchronous clear of match_cnt.
- flag  out  1  one-cycle registered match pulse.
- match_cnt  out  CNT_W  saturating count of matches.

Behaviour:
- Reset (rst=0, asynchronous):
  - hist, fill, flag and match_cnt all 0.
  - Config registers: pattern 0, mask 0, len 0, overlap 1. len 0 means disabled, so no flag until the first cfg_load.
- cfg_load=1 at an edge:
  - Latch all cfg_* fields; clear hist and fill; flag <= 0.
  - data_valid is ignored that cycle; match_cnt is unchanged.
- Effective length L:
  - cfg_len=0: detector disabled; flag never asserts.
  - cfg_len>PAT_W: clamped to PAT_W.
- History: hist[PAT_W-1:0], hist[0] = most recent valid bit.
  - Each valid edge: hist <= {hist[PAT_W-2:0], data}.
  - Invalid cycles leave hist and fill unchanged.
- Fill counter: counts valid bits since reset, cfg_load or a non-overlap match; saturates at PAT_W.
- Match condition, evaluated combinationally on nxt = {hist[PAT_W-2:0], data} while data_valid=1:
  - fill+1 >= L, and
  - for all i<L: ((nxt[i] ^ pattern[i]) & mask[i]) == 0.
  - Bits i>=L are ignored regardless of mask.
- Latency: flag is high for exactly the one cycle after the edge that samples the final pattern bit.
  - Back-to-back matches give consecutive flag cycles.
  - flag <= 0 on any edge without a match, including invalid cycles.
- Overlap mode 1: fill unaffected by a match; suffix bits count toward the next match.
- Overlap mode 0: on a match, fill <= 0. hist still shifts but is ignored until L new valid bits have arrived.
- match_cnt:
  - Increments by 1 per match; saturates at 2^CNT_W-1 (no wrap).
  - cnt_clr has priority: if clear and match fall on the same edge, result 0, but flag still pulses.
  - cfg_load does not clear match_cnt.
- All-zero mask with L>0: every valid bit matches once fill+1>=L.
- Reset mid-stream: partial history is lost; a pattern spanning reset release never matches.

Decomposition:
- Package seq_det_pkg:
  - default PAT_W/CNT_W constants;
  - cfg struct typedef {pattern, mask, len, overlap};
  - function clamp_len().
- Sub-module seq_det_cmp (combinational): inputs nxt, pattern, mask, L; output eq.
  - Builds the per-bit length-enable vector (i<L) and performs the masked compare.
- Top seq_detect_param holds the config registers, hist, fill, flag and counter.

Test Plan:
1. Overlap: pattern=8'h0B, mask=8'h0F, len=4, overlap=1; valid stream 1,0,1,1,0,1,1 -> flag pulses the cycle after bit 4 and after bit 7; match_cnt=2.
2. Non-overlap: same config with overlap=0, same stream -> one pulse, after bit 4, match_cnt=1. Then send 1,0,1,1 -> pulse after that 4th bit; match_cnt=2.
3. Valid gaps: test 1 stream with 1-3 data_valid=0 cycles between bits and data randomised while invalid -> identical pulse positions relative to valid bits; flag never high in the cycle after an invalid sample.
4. Mask and length:
   - pattern=8'b0000_1001, mask=8'b0000_1011, len=4 -> streams 1001 and 1101 both flag; 1000 does not.
   - len=9 with PAT_W=8 behaves as len=8.
   - len=0 never flags.
5. Counter (CNT_W=4):
   - 20 matches -> match_cnt holds 15.
   - cnt_clr asserted on a match edge -> match_cnt=0, flag=1.
   - Next match -> match_cnt=1.
6. Reset/config mid-stream:
   - Send 1,0,1, pulse rst low asynchronously between edges, release, send 1 -> no flag, match_cnt=0.
   - Repeat using cfg_load instead of rst -> no flag, match_cnt retains its prior value.
